// File: rtl/cache_reader.sv
// Consumer end of the random-bit shift cache: counts fresh bits, captures a WORD-bit window,
// destroys the consumed bits and offers the word on a valid/ready stream with a repeat check.
module cache_reader #(
  parameter int unsigned BITS = 256,
  parameter int unsigned WORD = 32
) (
  input  logic                     i_clock,
  input  logic                     i_rst,
  input  logic                     i_enb,
  input  logic                     i_shiftEnb,
  input  logic [BITS-1:0]          i_cacheData,
  output logic [BITS-1:1]          o_bitDestroy,
  output logic [WORD-1:0]          o_word,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(BITS)-1:0]  o_fill,
  output logic                     o_repeatErr
);

  localparam int unsigned FillW = $clog2(BITS);
  localparam logic [FillW-1:0] FillMax  = FillW'(BITS - 1);
  localparam logic [FillW-1:0] FillWord = FillW'(WORD);
  localparam logic [FillW-1:0] FillOne  = FillW'(1);
  // Bits 1..WORD set; bit 0 is dropped by the part-select below.
  localparam logic [BITS-1:0] MaskFull =
      ({{(BITS-1){1'b0}}, 1'b1} << (WORD + 1)) - BITS'(2);

  typedef enum logic [1:0] {StFill, StDestroy, StHold} state_e;

  state_e            state_q;
  logic [FillW-1:0]  fill_q;
  logic [WORD-1:0]   word_q;
  logic              valid_q;
  logic [BITS-1:1]   destroy_q;
  logic              err_q;
  logic              prev_vld_q;

  logic [WORD-1:0]   window;
  logic              unused_cache;

  assign window       = i_cacheData[WORD:1];
  assign unused_cache = ^{i_cacheData[0], i_cacheData[BITS-1:WORD]};

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StFill;
      fill_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      destroy_q  <= '0;
      err_q      <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      // The cache lets destroy win over shift, so a shift during DESTROY never lands in the window.
      if (state_q == StDestroy) begin
        fill_q <= '0;
      end else if (i_shiftEnb && (fill_q != FillMax)) begin
        fill_q <= fill_q + FillOne;
      end

      unique case (state_q)
        StFill: begin
          if (i_enb && (fill_q >= FillWord)) begin
            word_q     <= window;
            valid_q    <= 1'b1;
            prev_vld_q <= 1'b1;
            if (prev_vld_q && (window == word_q)) begin
              err_q <= 1'b1;
            end
            destroy_q  <= MaskFull[BITS-1:1];
            state_q    <= StDestroy;
          end
        end
        StDestroy: begin
          destroy_q <= '0;
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= StFill;
          end else begin
            state_q <= StHold;
          end
        end
        StHold: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign o_bitDestroy = destroy_q;
  assign o_word       = word_q;
  assign o_valid      = valid_q;
  assign o_fill       = fill_q;
  assign o_repeatErr  = err_q;

endmodule

// File: doc/cache_reader.md
# cache_reader

Consumer end of the random-bit shift cache. Counts fresh bits as they shift into the cache and captures a `WORD`-bit window once it is fully refreshed. On capture it pulses the cache's per-bit destroy lines so no bit is ever delivered twice, then presents the word on a valid/ready stream. Sits between the cache and any core-side consumer (key/nonce logic, bus register); also flags back-to-back identical words as a health fault.

## Interface
- `BITS`, 256: cache width; must match the cache instance.
- `WORD`, 32: output word width; legal range 1 ≤ `WORD` ≤ `BITS`-1.
- `i_clock`  in  1  single clock; same clock as the cache shift path.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_enb`  in  1  capture enable; fill counting continues when low.
- `i_shiftEnb`  in  1  copy of the cache shift enable; one fresh bit enters bit 1 per high cycle.
- `i_cacheData`  in  `BITS`  cache contents.
- `o_bitDestroy`  out  `BITS`-1  destroy mask to cache, index 1..`BITS`-1.
- `o_word`  out  `WORD`  captured random word.
- `o_valid`  out  1  `o_word` holds an undelivered word.
- `i_ready`  in  1  consumer accepts `o_word` when high with `o_valid`.
- `o_fill`  out  clog2(`BITS`)  fresh-bit count in window, saturating at `BITS`-1.
- `o_repeatErr`  out  1  sticky: two consecutive captured words were equal.

## Operation
- Window = `i_cacheData[WORD:1]`; bit 0 is never read or destroyed.
- Fill counter: +1 on each `i_shiftEnb` cycle, saturates at `BITS`-1; cleared to 0 on the edge that ends a destroy cycle, regardless of `i_shiftEnb` in that cycle (cache gives destroy priority over shift, so that shift is lost to the window).
- States: FILL, DESTROY, HOLD.
- FILL: at an edge where `i_enb`=1 and registered fill ≥ `WORD`: register `o_word` ← window, set `o_valid`=1, compare against previous captured word, go DESTROY.
- DESTROY (exactly one cycle): `o_bitDestroy[WORD:1]` all 1, all higher bits 0; `o_valid` stays 1. If `o_valid && i_ready` in this cycle: → FILL, `o_valid` ← 0; else → HOLD.
- HOLD: `o_bitDestroy` = 0, `o_word` stable, `o_valid`=1; on `o_valid && i_ready` → FILL, `o_valid` ← 0. Fill keeps counting in HOLD.
- Repeat check: if new capture equals previous capture (previous register valid after first capture since reset), `o_repeatErr` ← 1, held until reset. Word still delivered.
- `o_bitDestroy` is registered; never high outside DESTROY; never touches bits above `WORD`.

## Timing
- Reset values: state FILL, `o_word` 0, `o_valid` 0, `o_bitDestroy` 0, `o_fill` 0, `o_repeatErr` 0, previous-word register invalid. Reset takes effect immediately, mid-destroy included.
- Capture latency: word registered at the first edge with fill ≥ `WORD` and `i_enb`=1; `o_valid` high the following cycle.
- Destroy pulse is high the cycle immediately after the capture edge; cache clears at the end of that cycle, fill is 0 the cycle after.
- Shift at the capture edge: the captured word is the pre-shift window; that bit is destroyed along with the rest.
- Minimum capture-to-capture spacing: 1 (DESTROY) + `WORD` shift cycles + 1 evaluate edge, provided the consumer accepts in time.
- Word accepted in DESTROY or HOLD with fill already ≥ `WORD`: cannot occur in DESTROY (fill cleared); from HOLD, next capture on the first FILL edge.
- `i_enb` low in FILL: no capture, no destroy, `o_valid` remains 0.

## Test plan
- Reset, hold `i_shiftEnb`=1, `i_enb`=1, `i_ready`=1, window preloaded 0xA5A5_5A5A after 32 shifts -> `o_word`=0xA5A5_5A5A, `o_valid` high 1 cycle later, `o_bitDestroy`=bits[32:1] set for exactly one cycle, `o_fill`=0 next cycle.
- Only 31 shifts then stop -> no capture, `o_valid`=0, `o_bitDestroy`=0 indefinitely; 32nd shift -> capture next edge.
- `i_ready`=0 for 50 cycles with continuous shifts -> `o_word` stable, `o_fill` reaches 50 (saturates at 255 if held long), single destroy pulse; raise `i_ready` -> next capture on the first FILL edge.
- `i_shiftEnb`=1 in the destroy cycle -> `o_fill`=0 afterwards (shift not counted).
- Two consecutive captures of 0x0000_0000 -> `o_repeatErr`=1, stays 1 through later differing words until `i_rst`.
- Assert `i_rst` during DESTROY -> `o_bitDestroy`, `o_valid`, `o_fill` go 0 immediately; after release, a full 32 shifts are required before the next capture.
